// File: rtl/iob_core_mem_arbiter_pkg.sv
// Shared intercon definitions for the core memory arbiter.
// Field widths, state encoding and small sizing helpers.
package iob_core_mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_core_mem_arbiter_if.sv
// Native-bus bundle between the masters, the arbiter and memory.
// Requests are {valid, addr, wdata, wstrb}; responses {rdata, ready}.
interface iob_core_mem_arbiter_if
    import iob_core_mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);

    logic [N_MASTERS*REQ_W-1:0]  m_req;
    logic [N_MASTERS*RESP_W-1:0] m_resp;
    logic [REQ_W-1:0]            s_req;
    logic [RESP_W-1:0]           s_resp;

    modport master (
        output m_req,
        output s_resp,
        input  m_resp,
        input  s_req
    );

    modport slave (
        input  m_req,
        input  s_resp,
        output m_resp,
        output s_req
    );

endinterface

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin pick: first requester above last,
// wrapping to the lowest index.
module iob_rr_arbiter
    import iob_core_mem_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any_req
);

    logic [IW-1:0] g_hi;
    logic [IW-1:0] g_lo;
    logic          hit_hi;
    logic          hit_lo;

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        g_hi   = '0;
        g_lo   = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                g_hi   = IW'(i);
                hit_hi = 1'b1;
            end
            if (req[i] && (i <= int'(last))) begin
                g_lo   = IW'(i);
                hit_lo = 1'b1;
            end
        end
        grant   = hit_hi ? g_hi : g_lo;
        any_req = hit_hi | hit_lo;
    end

endmodule

// File: rtl/iob_core_mem_arbiter.sv
// Merges N native master buses onto one memory bus, one
// outstanding transaction at a time, round-robin fair.
module iob_core_mem_arbiter
    import iob_core_mem_arbiter_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int TIMEOUT   = 1024,
    localparam int GW        = idx_w(N_MASTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    iob_core_mem_arbiter_if.slave bus,
    output logic [GW-1:0]         grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int REQ_W  = req_w(ADDR_W, DATA_W);
    localparam int RESP_W = resp_w(DATA_W);
    localparam int TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX =
        TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t          state;
    logic [REQ_W-1:0]    req_q;
    logic [GW-1:0]       rr_last;
    logic [TO_W-1:0]     to_cnt;
    logic [N_MASTERS-1:0] m_valid;
    logic [GW-1:0]       pick;
    logic                any_req;
    logic [REQ_W-2:0]    pick_body;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    assign mem_ready = bus.s_resp[0];
    assign mem_rdata = bus.s_resp[RESP_W-1:1];

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = bus.m_req[i*REQ_W+REQ_W-1];
        end
    end

    iob_rr_arbiter #(
        .N(N_MASTERS)
    ) u_rr (
        .req    (m_valid),
        .last   (rr_last),
        .grant  (pick),
        .any_req(any_req)
    );

    always_comb begin
        pick_body = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (GW'(i) == pick) begin
                pick_body = bus.m_req[i*REQ_W +: REQ_W-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            grant       <= '0;
            rr_last     <= GW'(N_MASTERS - 1);
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (any_req) begin
                        req_q <= {1'b1, pick_body};
                        grant <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (TIMEOUT != 0 && to_cnt == TO_MAX) begin
                        timeout_err <= 1'b1;
                    end
                    if (mem_ready) begin
                        req_q   <= '0;
                        rr_last <= grant;
                        to_cnt  <= '0;
                        state   <= IDLE;
                    end else if (TIMEOUT != 0 && to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response path is combinational so memory ready reaches
    // the owner in the same cycle.
    always_comb begin
        bus.m_resp = '0;
        if (state == BUSY && mem_ready) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (GW'(i) == grant) begin
                    bus.m_resp[i*RESP_W +: RESP_W] = {mem_rdata, 1'b1};
                end
            end
        end
    end

    assign bus.s_req = req_q;
    assign busy      = (state == BUSY);

endmodule
